// File: rtl/addx_cross_pkg.sv
// Shared definitions for the addx cross-add final stage: FSM encodings, default moduli
// and the per-channel modular add/sub helper.
package addx_cross_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

   localparam int FN_W = 64;

   localparam logic [1:0][34:0] DEFAULT_Q = {35'h4_0008_0001, 35'h4_0800_0001};

   // Operands are assumed already reduced (< q); the extra top bit absorbs the carry/borrow.
   function automatic logic [FN_W-1:0] mod_add_sub(input logic [FN_W-1:0] a,
                                                   input logic [FN_W-1:0] b,
                                                   input logic [FN_W-1:0] q,
                                                   input logic            sub);
      logic [FN_W:0] s;
      if (sub) begin
         s = {1'b0, a} - {1'b0, b};
         if (a < b) s = s + {1'b0, q};
      end else begin
         s = {1'b0, a} + {1'b0, b};
         if (s >= {1'b0, q}) s = s - {1'b0, q};
      end
      return s[FN_W-1:0];
   endfunction

endpackage

// File: rtl/cross_modadd_last_seq_n_if.sv
// Data-path bundle of the cross-add stage: VPU element stream, PP BRAM read port and result outputs.
interface cross_modadd_last_seq_n_if #(
   parameter int N_POLY     = 2,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12
);
   logic [N_POLY*DATA_WIDTH-1:0] i_data_vpu;
   logic [ADDR_WIDTH-1:0]        i_addr_vpu;
   logic                         i_we_vpu;
   logic [N_POLY*DATA_WIDTH-1:0] i_data_pp;
   logic [ADDR_WIDTH-1:0]        o_addr_g0;
   logic                         o_en_bram_g0;
   logic [N_POLY*DATA_WIDTH-1:0] o_data;
   logic                         o_valid;
   logic [N_POLY*DATA_WIDTH-1:0] o_data_rb;
   logic [ADDR_WIDTH-1:0]        o_addr_rb;
   logic                         o_we_rb;

   modport master (
      output i_data_vpu, i_addr_vpu, i_we_vpu, i_data_pp,
      input  o_addr_g0, o_en_bram_g0, o_data, o_valid, o_data_rb, o_addr_rb, o_we_rb
   );

   modport slave (
      input  i_data_vpu, i_addr_vpu, i_we_vpu, i_data_pp,
      output o_addr_g0, o_en_bram_g0, o_data, o_valid, o_data_rb, o_addr_rb, o_we_rb
   );
endinterface

// File: rtl/cross_modadd_lane.sv
// One residue channel: registered modular add (or subtract) of the delayed VPU word and the PP word.
module cross_modadd_lane
   import addx_cross_pkg::*;
#(
   parameter int                       DATA_WIDTH    = 64,
   parameter int                       MODULUS_WIDTH = 35,
   parameter logic [MODULUS_WIDTH-1:0] Q_LANE        = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     sub,
   input  logic [MODULUS_WIDTH-1:0] a,
   input  logic [MODULUS_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0]    res
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res <= '0;
      end else if (en) begin
         res <= DATA_WIDTH'(MODULUS_WIDTH'(mod_add_sub(FN_W'(a), FN_W'(b), FN_W'(Q_LANE), sub)));
      end
   end

endmodule

// File: rtl/cross_modadd_last_seq_n.sv
// Final cross-add stage: PP BRAM read issue, VPU delay line, N_POLY modular lanes and transform FSM.
// Build option: define CROSS_MODADD_SUB_EN to let the latched i_op_sub select modular subtraction.
module cross_modadd_last_seq_n
   import addx_cross_pkg::*;
#(
   parameter int N_POLY        = 2,
   parameter int DATA_WIDTH    = 64,
   parameter int MODULUS_WIDTH = 35,
   parameter int ADDR_WIDTH    = 12,
   parameter int LEVEL_WIDTH   = 4,
   parameter int BRAM_LATENCY  = 1,
   parameter logic [N_POLY-1:0][MODULUS_WIDTH-1:0] Q = DEFAULT_Q
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_start,
   input  logic [LEVEL_WIDTH-1:0] i_n,
   input  logic                   i_s7_mode,
   input  logic                   i_op_sub,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [LEVEL_WIDTH-1:0] o_n_c1,
   cross_modadd_last_seq_n_if.slave bus
);

   // state | meaning
   // IDLE  | waiting for i_start; VPU writes ignored
   // RUN   | accepting elements, counting up to 2^n - 1
   // DRAIN | last element accepted; BRAM_LATENCY+1 cycles for the pipeline to empty
   // DONE  | one-cycle o_done, then back to IDLE

   localparam int MW = MODULUS_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int BL = BRAM_LATENCY;

   state_t                 state;
   logic [LEVEL_WIDTH-1:0] n_lat;
   logic                   s7_lat;
   logic                   sub_eff;
   logic [ADDR_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0]  last_idx;
   logic [2:0]             drain_cnt;
   logic                   we_acc;

   logic [N_POLY*MW-1:0]   vpu_low;
   logic [N_POLY*MW-1:0]   vpu_sr  [BL];
   logic [ADDR_WIDTH-1:0]  addr_sr [BL];
   logic [BL-1:0]          we_sr;
   logic [N_POLY*DW-1:0]   data_res;
   logic [N_POLY-1:0]      hi_bits_unused;

   assign we_acc           = bus.i_we_vpu & (state == RUN);
   assign bus.o_en_bram_g0 = we_acc;
   assign bus.o_addr_g0    = bus.i_addr_vpu;
   assign o_n_c1           = i_n;
   assign o_busy           = (state != IDLE);
   assign o_done           = (state == DONE);

   // Levels at or beyond the address width saturate to a full 2^ADDR_WIDTH sweep.
   always_comb begin
      last_idx = '1;
      if (int'(n_lat) < ADDR_WIDTH) begin
         last_idx = ADDR_WIDTH'(((ADDR_WIDTH+1)'(1) << n_lat) - (ADDR_WIDTH+1)'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         n_lat     <= '0;
         s7_lat    <= 1'b0;
         cnt       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state  <= RUN;
                  n_lat  <= i_n;
                  s7_lat <= i_s7_mode;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (bus.i_we_vpu) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == last_idx) begin
                     state     <= DRAIN;
                     drain_cnt <= 3'(BL);
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state <= DONE;
               else                 drain_cnt <= drain_cnt - 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CROSS_MODADD_SUB_EN
   logic sub_lat;

   always_ff @(posedge clk) begin
      if (!rst_n)                          sub_lat <= 1'b0;
      else if ((state == IDLE) && i_start) sub_lat <= i_op_sub;
   end

   assign sub_eff = sub_lat;
`else
   logic op_sub_unused;

   assign op_sub_unused = i_op_sub;
   assign sub_eff       = 1'b0;
`endif

   // Only the low MODULUS_WIDTH bits of each word take part in the arithmetic.
   for (genvar g = 0; g < N_POLY; g++) begin : g_pack
      assign vpu_low[g*MW +: MW] = bus.i_data_vpu[g*DW +: MW];
      assign hi_bits_unused[g]   = ^{bus.i_data_vpu[g*DW+MW +: DW-MW], bus.i_data_pp[g*DW+MW +: DW-MW]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BL; i++) begin
            vpu_sr[i]  <= '0;
            addr_sr[i] <= '0;
         end
         we_sr         <= '0;
         bus.o_valid   <= 1'b0;
         bus.o_addr_rb <= '0;
         bus.o_we_rb   <= 1'b0;
      end else begin
         vpu_sr[0]  <= vpu_low;
         addr_sr[0] <= bus.i_addr_vpu;
         we_sr[0]   <= we_acc;
         for (int i = 1; i < BL; i++) begin
            vpu_sr[i]  <= vpu_sr[i-1];
            addr_sr[i] <= addr_sr[i-1];
            we_sr[i]   <= we_sr[i-1];
         end
         bus.o_valid   <= we_sr[BL-1];
         bus.o_addr_rb <= addr_sr[BL-1];
         bus.o_we_rb   <= we_sr[BL-1] & ~s7_lat;
      end
   end

   for (genvar g = 0; g < N_POLY; g++) begin : g_lane
      cross_modadd_lane #(
         .DATA_WIDTH    (DW),
         .MODULUS_WIDTH (MW),
         .Q_LANE        (Q[g])
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (we_sr[BL-1]),
         .sub   (sub_eff),
         .a     (vpu_sr[BL-1][g*MW +: MW]),
         .b     (bus.i_data_pp[g*DW +: MW]),
         .res   (data_res[g*DW +: DW])
      );
   end

   assign bus.o_data    = data_res;
   assign bus.o_data_rb = data_res;

endmodule

// File: tb/tb_cross_modadd_last_seq_n.sv
// Scoreboard bench: two instances (BRAM latency 1 and 3) share stimulus; each has its own PP BRAM model.
module tb_cross_modadd_last_seq_n;

   localparam longint unsigned Q0 = 64'h4_0800_0001;
   localparam longint unsigned Q1 = 64'h4_0008_0001;

   typedef struct {
      logic [127:0] data;
      logic [11:0]  addr;
      logic         we_rb;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_r = 1'b0;
   logic [3:0] n_r = '0;
   logic s7_r = 1'b0;
   logic sub_r = 1'b0;
   logic [127:0] vpu_data = '0;
   logic [11:0] vpu_addr = '0;
   logic vpu_we = 1'b0;

   logic busy1, done1, busy3, done3;
   logic [3:0] nc1_1, nc1_3;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_cyc = 0;
   int done_n1 = 0, done_n3 = 0, done_cyc1 = 0, done_cyc3 = 0;
   bit cur_s7 = 1'b0;
   bit cur_sub = 1'b0;
   exp_t q1[$], q3[$];
   exp_t e1, e3;

   logic [127:0] pp_mem [16];
   logic [127:0] pp1_pipe;
   logic [127:0] pp3_pipe [3];

   cross_modadd_last_seq_n_if #(.N_POLY(2), .DATA_WIDTH(64), .ADDR_WIDTH(12)) bus1 ();
   cross_modadd_last_seq_n_if #(.N_POLY(2), .DATA_WIDTH(64), .ADDR_WIDTH(12)) bus3 ();

   assign bus1.i_data_vpu = vpu_data;
   assign bus1.i_addr_vpu = vpu_addr;
   assign bus1.i_we_vpu   = vpu_we;
   assign bus1.i_data_pp  = pp1_pipe;
   assign bus3.i_data_vpu = vpu_data;
   assign bus3.i_addr_vpu = vpu_addr;
   assign bus3.i_we_vpu   = vpu_we;
   assign bus3.i_data_pp  = pp3_pipe[2];

   cross_modadd_last_seq_n #(.BRAM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start_r), .i_n(n_r), .i_s7_mode(s7_r),
      .i_op_sub(sub_r), .o_busy(busy1), .o_done(done1), .o_n_c1(nc1_1), .bus(bus1)
   );

   cross_modadd_last_seq_n #(.BRAM_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .i_start(start_r), .i_n(n_r), .i_s7_mode(s7_r),
      .i_op_sub(sub_r), .o_busy(busy3), .o_done(done3), .o_n_c1(nc1_3), .bus(bus3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // PP BRAM models: read data appears BRAM_LATENCY cycles after the enable cycle
   always @(posedge clk) begin
      pp1_pipe    <= pp_mem[bus1.o_addr_g0[3:0]];
      pp3_pipe[0] <= pp_mem[bus3.o_addr_g0[3:0]];
      pp3_pipe[1] <= pp3_pipe[0];
      pp3_pipe[2] <= pp3_pipe[1];
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned model(input longint unsigned a, input longint unsigned b,
                                             input longint unsigned q);
`ifdef CROSS_MODADD_SUB_EN
      if (cur_sub) return (a + q - b) % q;
`endif
      return (a + b) % q;
   endfunction

   always @(negedge clk) begin
      if (done1) begin done_n1++; done_cyc1 = cyc; end
      if (bus1.o_valid) begin
         if (q1.size() == 0) chk("valid1_unexpected", 1'b1, 1'b0);
         else begin
            e1 = q1.pop_front();
            chk("data1", bus1.o_data, e1.data);
            chk("data_rb1", bus1.o_data_rb, e1.data);
            chk("addr_rb1", bus1.o_addr_rb, e1.addr);
            chk("we_rb1", bus1.o_we_rb, e1.we_rb);
            chk("lat1", cyc, e1.cyc + 2);
         end
      end else if (bus1.o_we_rb) chk("we_rb1_idle", 1'b1, 1'b0);
   end

   always @(negedge clk) begin
      if (done3) begin done_n3++; done_cyc3 = cyc; end
      if (bus3.o_valid) begin
         if (q3.size() == 0) chk("valid3_unexpected", 1'b1, 1'b0);
         else begin
            e3 = q3.pop_front();
            chk("data3", bus3.o_data, e3.data);
            chk("addr_rb3", bus3.o_addr_rb, e3.addr);
            chk("we_rb3", bus3.o_we_rb, e3.we_rb);
            chk("lat3", cyc, e3.cyc + 4);
         end
      end else if (bus3.o_we_rb) chk("we_rb3_idle", 1'b1, 1'b0);
   end

   task automatic start(input logic [3:0] n, input bit s7, input bit sub, input bit upd);
      start_r = 1'b1; n_r = n; s7_r = s7; sub_r = sub;
      if (upd) begin cur_s7 = s7; cur_sub = sub; end
      #1;
      chk("n_c1", nc1_1, n);
      @(negedge clk);
      start_r = 1'b0;
   endtask

   task automatic elem(input logic [11:0] a, input longint unsigned v0, input longint unsigned v1,
                       input longint unsigned p0, input longint unsigned p1, input bit acc);
      exp_t e;
      vpu_data = {64'(v1), 64'(v0)};
      vpu_addr = a;
      vpu_we   = 1'b1;
      pp_mem[a[3:0]] = {64'(p1), 64'(p0)};
      if (acc) begin
         e.data  = {64'(model(v1, p1, Q1)), 64'(model(v0, p0, Q0))};
         e.addr  = a;
         e.we_rb = ~cur_s7;
         e.cyc   = cyc;
         q1.push_back(e);
         q3.push_back(e);
      end
      last_cyc = cyc;
      #1;
      chk("addr_g0", bus1.o_addr_g0, a);
      chk("en1", bus1.o_en_bram_g0, acc);
      chk("en3", bus3.o_en_bram_g0, acc);
      @(negedge clk);
      vpu_we = 1'b0;
   endtask

   task automatic wait_done();
      int b1 = done_n1;
      int b3 = done_n3;
      int t = 0;
      while ((done_n1 == b1 || done_n3 == b3) && t < 40) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("done1_count", done_n1, b1 + 1);
      chk("done3_count", done_n3, b3 + 1);
      chk("done1_cyc", done_cyc1, last_cyc + 3);
      chk("done3_cyc", done_cyc3, last_cyc + 5);
      chk("q1_empty", q1.size(), 0);
      chk("q3_empty", q3.size(), 0);
      chk("busy1_end", busy1, 1'b0);
      chk("busy3_end", busy3, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      longint unsigned r0, r1, s0, s1;
      int b1, b3;
      repeat (3) @(negedge clk);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_done1", done1, 1'b0);
      chk("rst_valid1", bus1.o_valid, 1'b0);
      chk("rst_we_rb1", bus1.o_we_rb, 1'b0);
      chk("rst_data1", bus1.o_data, '0);
      chk("rst_busy3", busy3, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // wrap-around add, results to reduce buffer
      start(4'd2, 1'b0, 1'b0, 1'b1);
      chk("busy1_run", busy1, 1'b1);
      for (int i = 0; i < 4; i++) elem(12'(i), Q0 - 1, Q1 - 1, 2, 2, 1'b1);
      wait_done();

      // no-wrap add, then the same with s7 mode
      start(4'd1, 1'b0, 1'b0, 1'b1);
      elem(12'd0, 7, 5, 4, 3, 1'b1);
      elem(12'd1, 7, 5, 4, 3, 1'b1);
      wait_done();
      start(4'd1, 1'b1, 1'b0, 1'b1);
      elem(12'd2, 7, 5, 4, 3, 1'b1);
      elem(12'd3, 7, 5, 4, 3, 1'b1);
      wait_done();

      // subtract select (addition only when the feature is not built in)
      start(4'd1, 1'b0, 1'b1, 1'b1);
      elem(12'd0, 3, 3, 5, 5, 1'b1);
      elem(12'd1, 9, 9, 9, 9, 1'b1);
      wait_done();

      // writes in IDLE are ignored; a start during RUN is ignored
      for (int i = 0; i < 3; i++) elem(12'(5 + i), 1, 1, 1, 1, 1'b0);
      start(4'd2, 1'b0, 1'b0, 1'b1);
      elem(12'd0, 10, 20, 30, 40, 1'b1);
      elem(12'd1, 11, 21, 31, 41, 1'b1);
      start(4'd0, 1'b1, 1'b1, 1'b0);
      elem(12'd2, 12, 22, 32, 42, 1'b1);
      elem(12'd3, 13, 23, 33, 43, 1'b1);
      wait_done();

      // random operands with gaps between writes
      start(4'd3, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 8; i++) begin
         r0 = {$urandom, $urandom} % Q0; r1 = {$urandom, $urandom} % Q1;
         s0 = {$urandom, $urandom} % Q0; s1 = {$urandom, $urandom} % Q1;
         elem(12'(i), r0, r1, s0, s1, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_done();

      // reset mid-transform aborts without o_done
      start(4'd2, 1'b0, 1'b0, 1'b1);
      elem(12'd0, 1, 2, 3, 4, 1'b1);
      elem(12'd1, 5, 6, 7, 8, 1'b1);
      b1 = done_n1; b3 = done_n3;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid1", bus1.o_valid, 1'b0);
      chk("abort_valid3", bus3.o_valid, 1'b0);
      chk("abort_busy1", busy1, 1'b0);
      chk("abort_busy3", busy3, 1'b0);
      chk("abort_done1", done1, 1'b0);
      q1.delete();
      q3.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done1", done_n1, b1);
      chk("abort_no_done3", done_n3, b3);
      start(4'd2, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) elem(12'(i), 100 + i, 200 + i, Q0 - 50, Q1 - 150, 1'b1);
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cross_modadd_last_seq_n.md
Name: cross_modadd_last_seq_n

Overview:
Final cross-add stage of the addx pipeline, generalised to N_POLY residue channels with per-channel moduli and a configurable BRAM read latency. For each VPU write it issues a read of the upper-stage partial product (PP) BRAM. It adds the VPU data to the returned PP data modulo q_i, then routes the result to stage 3 or the reduce buffer. A start/count/drain FSM tracks a 2^i_n element transform and produces a one-cycle o_done.

Parameters:
N_POLY, 2, number of residue channels
DATA_WIDTH, 64, storage word width; results zero-extended to this
MODULUS_WIDTH, 35, modulus bit length; must be < DATA_WIDTH
ADDR_WIDTH, 12, BRAM address width
LEVEL_WIDTH, 4, width of i_n
BRAM_LATENCY, 1, cycles from o_en_bram_g0 to valid i_data_pp; range 1..4
Q, {35'h4_0008_0001, 35'h4_0800_0001}, packed [N_POLY-1:0][MODULUS_WIDTH-1:0]; channel i uses Q[i]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset (one clock; reset sampled on rising edge of clk only)
i_start  in  1  one-cycle pulse that begins a transform
i_n  in  LEVEL_WIDTH  log2 of element count for the transform
i_data_vpu  in  N_POLY*DATA_WIDTH  VPU operand per channel, valid with i_we_vpu
i_addr_vpu  in  ADDR_WIDTH  element address
i_we_vpu  in  1  element valid
i_data_pp  in  N_POLY*DATA_WIDTH  PP BRAM read data, BRAM_LATENCY after read enable
i_s7_mode  in  1  1: results to o_data only; 0: results also written to reduce buffer
i_op_sub  in  1  subtract select (see Optional Feature)
o_addr_g0  out  ADDR_WIDTH  PP BRAM read address (= i_addr_vpu, combinational)
o_en_bram_g0  out  1  PP BRAM read enable (= i_we_vpu & state==RUN)
o_data  out  N_POLY*DATA_WIDTH  result to stage 3
o_valid  out  1  o_data valid
o_data_rb  out  N_POLY*DATA_WIDTH  result to reduce buffer (same as o_data)
o_addr_rb  out  ADDR_WIDTH  reduce buffer write address
o_we_rb  out  1  reduce buffer write enable = o_valid & ~s7_mode captured at start
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at transform end
o_n_c1  out  LEVEL_WIDTH  i_n forwarded combinationally

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE; all pipeline registers, counter, o_data, o_valid, o_we_rb, o_addr_rb, o_done, and o_busy are 0. A reset mid-transform aborts it with no o_done.
- FSM IDLE -> RUN on i_start; latch i_n, i_s7_mode, i_op_sub; clear the element counter. i_start outside IDLE is ignored.
- RUN: each i_we_vpu increments the counter. When the counter reaches 2^i_n - 1 and i_we_vpu is high, go to DRAIN. i_n >= ADDR_WIDTH saturates the count to 2^ADDR_WIDTH.
- DRAIN: wait BRAM_LATENCY+1 cycles (the pipeline empties), then DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- i_we_vpu outside RUN is ignored: no BRAM enable, no output.
- Pipeline: i_data_vpu, i_addr_vpu, and the accepted write enable are delayed BRAM_LATENCY cycles in a shift register. The delayed VPU data is combined with i_data_pp and registered. Total latency from i_we_vpu to o_valid is BRAM_LATENCY+1; II=1.
- Arithmetic per channel, using low MODULUS_WIDTH bits of the operands; operands must be < Q[i]:
  - add: s = a + b at MODULUS_WIDTH+1 bits; result = (s >= Q[i]) ? s - Q[i] : s.
  - sub: d = a - b; result = (a < b) ? d + Q[i] : d.
  - Result is zero-extended to DATA_WIDTH.
- o_addr_rb is the address delayed by BRAM_LATENCY+1; it is valid with o_valid.

Optional Feature:
Macro CROSS_MODADD_SUB_EN.
- Defined: the latched i_op_sub selects modular subtraction (VPU minus PP) for all channels for that transform.
- Undefined: the i_op_sub port is present but ignored; addition only, and no subtractor logic is generated.

Decomposition:
- Package addx_cross_pkg: state enum (IDLE, RUN, DRAIN, DONE); a default-modulus constant array; the function mod_add_sub(a, b, q, sub).
- One sub-module, cross_modadd_lane: a single channel's registered modular add/sub, instantiated N_POLY times in a generate loop.

Test Plan:
- Add, N_POLY=2, i_n=2, i_s7_mode=0. Four elements at addr 0..3: vpu={Q1-1, Q0-1}, pp={2,2}. Expect o_data={1,1} at cycle +2 with BRAM_LATENCY=1; o_we_rb high 4 cycles, addr 0..3; o_done 1 cycle after DRAIN.
- No-wrap add: vpu={5,7}, pp={3,4} -> o_data={8,11}. With i_s7_mode=1: o_valid=1, o_we_rb=0.
- Sub (macro defined, i_op_sub=1): vpu={3,3}, pp={5,5} -> o_data={Q1-2, Q0-2}; vpu=pp -> 0. Macro undefined: same stimulus gives {8,8}.
- Enable gating: i_we_vpu pulses in IDLE produce no o_en_bram_g0 and no o_valid. A second i_start during RUN does not reset the counter; o_done occurs after exactly 2^i_n writes.
- BRAM_LATENCY=3 with gaps in i_we_vpu: each output appears exactly 4 cycles after its input, in order, with matching addresses.
- Reset mid-RUN after 2 of 4 writes: the next cycle has o_valid=0, o_busy=0, and no o_done. A fresh i_start completes normally.
